pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_seq_ret_stack.sv | 38 +++
 rtl/pc_seq.sv | 124 ++++++++++++
 tb/tb_pc_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM state encoding, branch-kind codes and
// the default return-stack depth.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [1:0] BR_JUMP = 2'b00;
  localparam logic [1:0] BR_CALL = 2'b01;
  localparam logic [1:0] BR_RET  = 2'b10;

  localparam int STACK_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO for pc_seq. Built only when PC_SEQ_RET_STACK_EN is defined;
// the caller guards push-when-full and pop-when-empty.
`ifdef PC_SEQ_RET_STACK_EN
module ret_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_data,
  output logic [15:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   mem_q [DEPTH];
  logic [CW-1:0] cnt_q;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = empty ? 16'h0000 : mem_q[cnt_q - CW'(1)];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[cnt_q] <= push_data;
      cnt_q        <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/pc_seq.sv
// PC sequencer: fetches at the current pc, then issues one PC update pulse per fetch.
// Optional return stack for call/ret is enabled by the macro PC_SEQ_RET_STACK_EN.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt,
  input  logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic        br_dir,
  input  logic [1:0]  br_kind,
  input  logic [15:0] br_off,
  output logic        pc_inc,
  output logic        pc_add,
  output logic        pc_sub,
  output logic [15:0] pc_offset,
  output logic        busy,
  output logic        stack_err,
  output state_t      state_dbg
);

  // Branch handshake: br_ready is high only in UPDATE, and a branch is consumed
  // exactly when br_valid && br_ready in that single cycle.
  state_t state_q;
  logic   push, pop, err_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (run && !halt) state_q <= ST_FETCH;
        ST_FETCH:  if (mem_ack) state_q <= ST_UPDATE;
        ST_UPDATE: begin
          if (halt)     state_q <= ST_HALT;
          else if (run) state_q <= ST_FETCH;
          else          state_q <= ST_IDLE;
        end
        default:   state_q <= ST_HALT;
      endcase
    end
  end

  assign state_dbg = state_q;
  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = (state_q == ST_FETCH);
  assign mem_addr  = (state_q == ST_FETCH) ? pc : 16'h0000;
  assign br_ready  = (state_q == ST_UPDATE);

`ifdef PC_SEQ_RET_STACK_EN
  logic        stk_full, stk_empty, stack_err_q;
  logic [15:0] stk_top;

  ret_stack #(.DEPTH(STACK_DEPTH)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc + 16'd1),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)        stack_err_q <= 1'b0;
    else if (err_set) stack_err_q <= 1'b1;
  end

  assign stack_err = stack_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{br_kind, push, pop, err_set, STACK_DEPTH[0]};
  assign stack_err  = 1'b0;
`endif

  always_comb begin
    pc_inc    = 1'b0;
    pc_add    = 1'b0;
    pc_sub    = 1'b0;
    pc_offset = 16'h0000;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    if (state_q == ST_UPDATE) begin
      if (!br_valid) begin
        pc_inc = 1'b1;
      end
`ifdef PC_SEQ_RET_STACK_EN
      else if (br_kind == BR_RET) begin
        // Return is expressed as a forward add of the wrapped distance to the target.
        if (stk_empty) begin
          pc_inc  = 1'b1;
          err_set = 1'b1;
        end else begin
          pop       = 1'b1;
          pc_add    = 1'b1;
          pc_offset = stk_top - pc;
        end
      end
`endif
      else begin
`ifdef PC_SEQ_RET_STACK_EN
        if (br_kind == BR_CALL) begin
          if (stk_full) err_set = 1'b1;
          else          push    = 1'b1;
        end
`endif
        if (br_dir) pc_sub = 1'b1;
        else        pc_add = 1'b1;
        pc_offset = br_off;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq; stack scenarios run when
// PC_SEQ_RET_STACK_EN is defined.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0, run = 1'b0, halt = 1'b0, mem_ack = 1'b0;
  logic [15:0] pc = 16'h0000, br_off = 16'h0000;
  logic        br_valid = 1'b0, br_dir = 1'b0;
  logic [1:0]  br_kind = BR_JUMP;
  logic [15:0] mem_addr, pc_offset;
  logic        mem_req, br_ready, pc_inc, pc_add, pc_sub, busy, stack_err;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .pc(pc),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .br_valid(br_valid), .br_ready(br_ready), .br_dir(br_dir),
    .br_kind(br_kind), .br_off(br_off), .pc_inc(pc_inc), .pc_add(pc_add),
    .pc_sub(pc_sub), .pc_offset(pc_offset), .busy(busy),
    .stack_err(stack_err), .state_dbg(state_dbg)
  );

  // Advance one clock; inputs change 2 time units after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; halt = 1'b0; mem_ack = 1'b0; br_valid = 1'b0;
    br_kind = BR_JUMP; br_dir = 1'b0; br_off = 16'h0000;
    tick();
    reset = 1'b0;
  endtask

  // From IDLE or UPDATE with run=1: fetch at pc_val, ack at once, land in UPDATE.
  task automatic go_update(input logic [15:0] pc_val);
    run = 1'b1; halt = 1'b0;
    tick();
    br_valid = 1'b0; pc = pc_val; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b1; pc = 16'h0010;
    tick(); tick();
    do_reset();
    #1;
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    n_cmp++; if ({mem_req, br_ready, pc_inc, pc_add, pc_sub, busy, stack_err} !== 7'b0) begin n_err++; $display("FAIL rst_outs got=%b exp=0000000", {mem_req, br_ready, pc_inc, pc_add, pc_sub, busy, stack_err}); end
    n_cmp++; if (pc_offset !== 16'h0000) begin n_err++; $display("FAIL rst_offset got=%h exp=0000", pc_offset); end
  endtask

  task automatic test_fetch_inc();
    do_reset();
    run = 1'b1; pc = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 2) mem_ack = 1'b1;
      #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_hold c=%0d got req=%b addr=%h exp req=1 addr=0010", c, mem_req, mem_addr); end
    end
    tick();
    mem_ack = 1'b0; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub, br_ready, mem_req} !== 5'b10010) begin n_err++; $display("FAIL fetch_update got=%b exp=10010", {pc_inc, pc_add, pc_sub, br_ready, mem_req}); end
    n_cmp++; if (pc_offset !== 16'h0000) begin n_err++; $display("FAIL fetch_inc_off got=%h exp=0000", pc_offset); end
    tick(); #1;
    n_cmp++; if (mem_req !== 1'b1 || pc_inc !== 1'b0) begin n_err++; $display("FAIL fetch_next got req=%b inc=%b exp req=1 inc=0", mem_req, pc_inc); end
    run = 1'b0;
    tick(); #1;
    n_cmp++; if (state_dbg !== ST_FETCH || mem_req !== 1'b1) begin n_err++; $display("FAIL run_drop got state=%0d req=%b exp state=1 req=1", state_dbg, mem_req); end
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); #1;
    n_cmp++; if (state_dbg !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL back_idle got state=%0d busy=%b exp state=0 busy=0", state_dbg, busy); end
  endtask

  task automatic test_ack_ignored();
    do_reset();
    mem_ack = 1'b1;
    tick(); #1;
    n_cmp++; if (state_dbg !== ST_IDLE || pc_inc !== 1'b0 || br_ready !== 1'b0) begin n_err++; $display("FAIL ack_idle got state=%0d inc=%b rdy=%b exp state=0 inc=0 rdy=0", state_dbg, pc_inc, br_ready); end
    mem_ack = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    go_update(16'h0010);
    br_valid = 1'b1; br_dir = 1'b1; br_off = 16'h0020; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b001 || pc_offset !== 16'h0020) begin n_err++; $display("FAIL br_sub got=%b off=%h exp=001 off=0020", {pc_inc, pc_add, pc_sub}, pc_offset); end
    go_update(16'hFFF0);
    br_valid = 1'b1; br_dir = 1'b0; br_off = 16'h0000; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b010 || pc_offset !== 16'h0000) begin n_err++; $display("FAIL br_add0 got=%b off=%h exp=010 off=0000", {pc_inc, pc_add, pc_sub}, pc_offset); end
`ifndef PC_SEQ_RET_STACK_EN
    go_update(16'h0040);
    br_valid = 1'b1; br_dir = 1'b0; br_kind = BR_RET; br_off = 16'h0005; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b010 || pc_offset !== 16'h0005) begin n_err++; $display("FAIL kind_ignored got=%b off=%h exp=010 off=0005", {pc_inc, pc_add, pc_sub}, pc_offset); end
    run = 1'b0;
    tick(); #1;
    n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL no_stack_err got=%b exp=0", stack_err); end
    br_kind = BR_JUMP;
`endif
    run = 1'b0; br_valid = 1'b0;
    tick(); #1;
    n_cmp++; if (pc_add !== 1'b0 || pc_sub !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL br_after got add=%b sub=%b busy=%b exp 0 0 0", pc_add, pc_sub, busy); end
  endtask

  task automatic test_halt_branch();
    do_reset();
    go_update(16'h0010);
    br_valid = 1'b1; br_dir = 1'b0; br_off = 16'h0004; halt = 1'b1; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b010 || pc_offset !== 16'h0004) begin n_err++; $display("FAIL halt_br got=%b off=%h exp=010 off=0004", {pc_inc, pc_add, pc_sub}, pc_offset); end
    tick();
    halt = 1'b0; br_valid = 1'b0; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = c[0];
      #1;
      n_cmp++; if (state_dbg !== ST_HALT || busy !== 1'b1 || {mem_req, br_ready, pc_inc, pc_add, pc_sub} !== 5'b0) begin n_err++; $display("FAIL halt_hold c=%0d got state=%0d busy=%b outs=%b exp state=3 busy=1 outs=00000", c, state_dbg, busy, {mem_req, br_ready, pc_inc, pc_add, pc_sub}); end
      tick();
    end
    do_reset(); #1;
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL halt_exit got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1'b1; pc = 16'h0030;
    tick();
    mem_ack = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b0 || state_dbg !== ST_IDLE || pc_inc !== 1'b0) begin n_err++; $display("FAIL rst_fetch got req=%b state=%0d inc=%b exp req=0 state=0 inc=0", mem_req, state_dbg, pc_inc); end
    run = 1'b0;
    go_update(16'h0030);
    run = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub, br_ready} !== 4'b0 || state_dbg !== ST_IDLE) begin n_err++; $display("FAIL rst_update got=%b state=%0d exp=0000 state=0", {pc_inc, pc_add, pc_sub, br_ready}, state_dbg); end
  endtask

`ifdef PC_SEQ_RET_STACK_EN
  task automatic test_stack();
    do_reset();
    go_update(16'h0100);
    br_valid = 1'b1; br_kind = BR_CALL; br_dir = 1'b0; br_off = 16'h0100; #1;
    n_cmp++; if (pc_add !== 1'b1 || pc_offset !== 16'h0100) begin n_err++; $display("FAIL call_br got add=%b off=%h exp add=1 off=0100", pc_add, pc_offset); end
    go_update(16'h0200);
    br_valid = 1'b1; br_kind = BR_RET; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b010 || pc_offset !== 16'hFF01) begin n_err++; $display("FAIL ret_br got=%b off=%h exp=010 off=FF01", {pc_inc, pc_add, pc_sub}, pc_offset); end
    go_update(16'h0101);
    n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL ret_noerr got=%b exp=0", stack_err); end
    br_valid = 1'b1; br_kind = BR_RET; #1;
    n_cmp++; if ({pc_inc, pc_add, pc_sub} !== 3'b100) begin n_err++; $display("FAIL ret_empty got=%b exp=100", {pc_inc, pc_add, pc_sub}); end
    run = 1'b0;
    tick(); br_valid = 1'b0; #1;
    n_cmp++; if (stack_err !== 1'b1) begin n_err++; $display("FAIL ret_empty_err got=%b exp=1", stack_err); end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      go_update(16'h1000 + 16'(k));
      br_valid = 1'b1; br_kind = BR_CALL; br_dir = 1'b1; br_off = 16'h0008; #1;
      n_cmp++; if (pc_sub !== 1'b1 || pc_offset !== 16'h0008) begin n_err++; $display("FAIL call_k%0d got sub=%b off=%h exp sub=1 off=0008", k, pc_sub, pc_offset); end
      n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL call_err_k%0d got=%b exp=0", k, stack_err); end
    end
    run = 1'b0;
    tick(); br_valid = 1'b0; #1;
    n_cmp++; if (stack_err !== 1'b1) begin n_err++; $display("FAIL overflow_err got=%b exp=1", stack_err); end
    br_kind = BR_JUMP;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_inc();
    test_ack_ignored();
    test_branch();
    test_halt_branch();
    test_reset_mid_fetch();
`ifdef PC_SEQ_RET_STACK_EN
    test_stack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
